// File: rtl/nes_vga_timing.sv
// ---------------------------------------------------------------------------
// nes_vga_timing
//
// VGA 640x480@60 raster timing generator driven by a 25 MHz pixel strobe.
// Besides the usual sync / display-enable outputs it decodes a 2x scaled
// 256x240 NES picture window (512x480, horizontally centred) and issues one
// line-fetch request per NES line, one VGA line ahead of when it is shown.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (priority over ce_pix)
//   ce_pix       pixel strobe; all state advances only when high
//   hs, vs       horizontal / vertical sync, active low
//   x, y         current column 0..799 / line 0..524
//   de           display enable (visible 640x480 area)
//   nes_act      inside the NES window
//   nes_x/nes_y  NES pixel coordinates (0 outside the window)
//   line_req     one-clk pulse: fetch NES line nes_y_next
//   nes_y_next   line index accompanying line_req (held between pulses)
//   frame_start  one-clk pulse when the raster wraps to 0,0
//
// Every output is a register loaded from the decode of the *next* x/y, so
// the outputs describe the new raster position on the same clk the counters
// step.
// ---------------------------------------------------------------------------
module nes_vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int NES_X0 = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_pix,
    output logic       hs,
    output logic       vs,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       nes_act,
    output logic [7:0] nes_x,
    output logic [7:0] nes_y,
    output logic       line_req,
    output logic [7:0] nes_y_next,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
    localparam logic [9:0] V_LAST_VIS = 10'(V_VIS - 1);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] NES_LO     = 10'(NES_X0);
    localparam logic [9:0] NES_HI     = 10'(NES_X0 + 512);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       nes_act_q, nes_act_d;
    logic [7:0] nes_x_q, nes_x_d;
    logic [7:0] nes_y_q, nes_y_d;
    logic       line_req_q, line_req_d;
    logic [7:0] nes_y_next_q, nes_y_next_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        // Hold everything by default; pulses fall back to zero.
        x_d           = x_q;
        y_d           = y_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        nes_act_d     = nes_act_q;
        nes_x_d       = nes_x_q;
        nes_y_d       = nes_y_q;
        nes_y_next_d  = nes_y_next_q;
        line_req_d    = 1'b0;
        frame_start_d = 1'b0;

        // The decode is only refreshed on a strobe, so after reset the
        // outputs keep their reset values until the raster actually moves.
        if (ce_pix) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end

            hs_d      = !((x_d >= HS_START) && (x_d < HS_END));
            vs_d      = !((y_d >= VS_START) && (y_d < VS_END));
            de_d      = (x_d < H_VIS_W) && (y_d < V_VIS_W);
            nes_act_d = (x_d >= NES_LO) && (x_d < NES_HI) && (y_d < V_VIS_W);
            nes_x_d   = nes_act_d ? 8'((x_d - NES_LO) >> 1) : '0;
            nes_y_d   = nes_act_d ? 8'(y_d >> 1) : '0;

            // Odd lines prefetch the NES line shown on the next (even) VGA
            // line; the last line of the frame prefetches NES line 0. Line
            // V_VIS-1 is excluded since there is no NES line after it.
            line_req_d = (x_d == H_VIS_W) &&
                         ((y_d[0] && (y_d < V_LAST_VIS)) || (y_d == V_LAST));
            if (line_req_d) begin
                nes_y_next_d = (y_d == V_LAST) ? '0 : 8'((y_d + 10'd1) >> 1);
            end

            // Only a counter wrap lands on 0,0 here; a reset restart does not.
            frame_start_d = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            nes_act_q     <= 1'b0;
            nes_x_q       <= '0;
            nes_y_q       <= '0;
            line_req_q    <= 1'b0;
            nes_y_next_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            nes_act_q     <= nes_act_d;
            nes_x_q       <= nes_x_d;
            nes_y_q       <= nes_y_d;
            line_req_q    <= line_req_d;
            nes_y_next_q  <= nes_y_next_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign nes_act     = nes_act_q;
    assign nes_x       = nes_x_q;
    assign nes_y       = nes_y_q;
    assign line_req    = line_req_q;
    assign nes_y_next  = nes_y_next_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_nes_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_nes_vga_timing
//
// Two instances: "A" uses the real 640x480 timing, "B" keeps the horizontal
// timing but has a 14-line frame (8 visible, sync on lines 10..11) so whole
// frames, vsync, frame_start and the end-of-frame line request fit in a
// short run. Every driven clk pushes the expected output set into a queue;
// the task that drove it pops and compares once the DUT has registered it.
// ---------------------------------------------------------------------------
module tb_nes_vga_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       nes_act;
        logic [7:0] nes_x;
        logic [7:0] nes_y;
        logic       line_req;
        logic [7:0] nes_y_next;
        logic       frame_start;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, ce_a, rst_b, ce_b;
    logic       a_hs, a_vs, a_de, a_act, a_lr, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_nx, a_ny, a_nyn;
    logic       b_hs, b_vs, b_de, b_act, b_lr, b_fs;
    logic [9:0] b_x, b_y;
    logic [7:0] b_nx, b_ny, b_nyn;

    int   n_cmp  = 0;
    int   n_fail = 0;
    out_t exp_a, exp_b;
    out_t qa[$];
    out_t qb[$];

    nes_vga_timing u_a (
        .clk(clk), .rst(rst_a), .ce_pix(ce_a),
        .hs(a_hs), .vs(a_vs), .x(a_x), .y(a_y), .de(a_de),
        .nes_act(a_act), .nes_x(a_nx), .nes_y(a_ny),
        .line_req(a_lr), .nes_y_next(a_nyn), .frame_start(a_fs)
    );

    nes_vga_timing #(.V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_b (
        .clk(clk), .rst(rst_b), .ce_pix(ce_b),
        .hs(b_hs), .vs(b_vs), .x(b_x), .y(b_y), .de(b_de),
        .nes_act(b_act), .nes_x(b_nx), .nes_y(b_ny),
        .line_req(b_lr), .nes_y_next(b_nyn), .frame_start(b_fs)
    );

    function automatic out_t reset_val();
        out_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Reference model: vv = visible lines, vt = total lines, vs0 = first sync line.
    function automatic out_t next_exp(input out_t prev, input bit ce, input bit r,
                                      input int vv, input int vt, input int vs0);
        out_t o;
        int   nx, ny;
        bit   act, lr;
        if (r) return reset_val();
        o             = prev;
        o.line_req    = 1'b0;
        o.frame_start = 1'b0;
        if (!ce) return o;
        nx = int'(prev.x) + 1;
        ny = int'(prev.y);
        if (nx == 800) begin
            nx = 0;
            ny = (ny == vt - 1) ? 0 : ny + 1;
        end
        act           = (nx >= 64) && (nx < 576) && (ny < vv);
        lr            = (nx == 640) && (((ny % 2) == 1 && ny < vv - 1) || ny == vt - 1);
        o.x           = 10'(nx);
        o.y           = 10'(ny);
        o.hs          = !((nx >= 656) && (nx < 752));
        o.vs          = !((ny >= vs0) && (ny < vs0 + 2));
        o.de          = (nx < 640) && (ny < vv);
        o.nes_act     = act;
        o.nes_x       = act ? 8'((nx - 64) / 2) : 8'd0;
        o.nes_y       = act ? 8'(ny / 2) : 8'd0;
        o.line_req    = lr;
        if (lr) o.nes_y_next = (ny == vt - 1) ? 8'd0 : 8'((ny + 1) / 2);
        o.frame_start = (nx == 0) && (ny == 0);
        return o;
    endfunction

    function automatic out_t sample_a();
        out_t o;
        o = '{a_x, a_y, a_hs, a_vs, a_de, a_act, a_nx, a_ny, a_lr, a_nyn, a_fs};
        return o;
    endfunction

    function automatic out_t sample_b();
        out_t o;
        o = '{b_x, b_y, b_hs, b_vs, b_de, b_act, b_nx, b_ny, b_lr, b_nyn, b_fs};
        return o;
    endfunction

    task automatic drive_a(input bit ce, input bit r);
        ce_a  = ce;
        rst_a = r;
        exp_a = next_exp(exp_a, ce, r, 480, 525, 490);
        qa.push_back(exp_a);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input bit ce, input bit r);
        ce_b  = ce;
        rst_b = r;
        exp_b = next_exp(exp_b, ce, r, 8, 14, 10);
        qb.push_back(exp_b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t e, g;
        for (int i = 0; i < 4; i++) begin
            drive_a(i == 3, 1'b1);  // last one also has ce_pix high
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_a: got %h, expected %h", g, e);
            end
            drive_b(i == 3, 1'b1);
            e = qb.pop_front(); g = sample_b(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_b: got %h, expected %h", g, e);
            end
        end
        $display("reset: both instances at x=%0d y=%0d hs=%0d vs=%0d", a_x, a_y, a_hs, a_vs);
    endtask

    task automatic test_every4th();
        out_t e, g;
        int hs_cnt = 0, hs_first = -1, lr_cnt = 0;
        for (int i = 0; i < 6400; i++) begin
            drive_a((i % 4) == 3, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL every4th: got x=%0d y=%0d out=%h, expected x=%0d y=%0d out=%h",
                         g.x, g.y, g, e.x, e.y, e);
            end
            if ((i % 4) == 3 && g.y == 0 && g.hs == 1'b0) begin
                if (hs_cnt == 0) hs_first = int'(g.x);
                hs_cnt++;
            end
            if (g.line_req) begin
                lr_cnt++;
                $display("every4th: line_req y=%0d x=%0d nes_y_next=%0d", g.y, g.x, g.nes_y_next);
            end
        end
        n_cmp++;
        if (hs_cnt != 96) begin n_fail++; $display("FAIL hs_width: got %0d enables, expected 96", hs_cnt); end
        n_cmp++;
        if (hs_first != 656) begin n_fail++; $display("FAIL hs_start: got x=%0d, expected 656", hs_first); end
        n_cmp++;
        if (lr_cnt != 1) begin n_fail++; $display("FAIL every4th_lr: got %0d pulses, expected 1", lr_cnt); end
        n_cmp++;
        if (a_x !== 10'd0 || a_y !== 10'd2) begin
            n_fail++;
            $display("FAIL every4th_end: got x=%0d y=%0d, expected x=0 y=2", a_x, a_y);
        end
    endtask

    task automatic test_window_linereq();
        out_t e, g;
        int lr_cnt = 0, fs_cnt = 0;
        drive_a(1'b0, 1'b1);
        e = qa.pop_front(); g = sample_a(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL window_rst: got %h, expected %h", g, e); end
        for (int i = 0; i < 7200; i++) begin
            drive_a(1'b1, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL continuous: got x=%0d y=%0d out=%h, expected x=%0d y=%0d out=%h",
                         g.x, g.y, g, e.x, e.y, e);
            end
            if (g.y == 0 && g.x == 63) begin
                n_cmp++;
                if (g.nes_act !== 1'b0) begin n_fail++; $display("FAIL win_x63: got act=%0d, expected 0", g.nes_act); end
            end
            if (g.y == 0 && g.x == 64) begin
                n_cmp++;
                if (g.nes_act !== 1'b1 || g.nes_x !== 8'd0) begin
                    n_fail++;
                    $display("FAIL win_x64: got act=%0d nes_x=%0d, expected act=1 nes_x=0", g.nes_act, g.nes_x);
                end
            end
            if (g.y == 0 && g.x == 575) begin
                n_cmp++;
                if (g.nes_act !== 1'b1 || g.nes_x !== 8'd255) begin
                    n_fail++;
                    $display("FAIL win_x575: got act=%0d nes_x=%0d, expected act=1 nes_x=255", g.nes_act, g.nes_x);
                end
            end
            if (g.y == 0 && g.x == 576) begin
                n_cmp++;
                if (g.nes_act !== 1'b0 || g.nes_x !== 8'd0) begin
                    n_fail++;
                    $display("FAIL win_x576: got act=%0d nes_x=%0d, expected act=0 nes_x=0", g.nes_act, g.nes_x);
                end
            end
            if (g.frame_start) fs_cnt++;
            if (g.line_req) begin
                lr_cnt++;
                $display("continuous: line_req y=%0d x=%0d nes_y_next=%0d", g.y, g.x, g.nes_y_next);
                n_cmp++;
                if (g.x !== 10'd640 || g.y[0] !== 1'b1 || int'(g.nes_y_next) != (int'(g.y) + 1) / 2) begin
                    n_fail++;
                    $display("FAIL lr_point: got x=%0d y=%0d nyn=%0d, expected x=640 odd y nyn=(y+1)/2",
                             g.x, g.y, g.nes_y_next);
                end
            end
        end
        n_cmp++;
        if (lr_cnt != 4) begin n_fail++; $display("FAIL lr_count9: got %0d, expected 4", lr_cnt); end
        n_cmp++;
        if (fs_cnt != 0) begin n_fail++; $display("FAIL fs_after_rst: got %0d, expected 0", fs_cnt); end
    endtask

    task automatic test_freeze();
        out_t e, g;
        int pulses = 0;
        drive_a(1'b0, 1'b1);
        e = qa.pop_front(); g = sample_a(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL freeze_rst: got %h, expected %h", g, e); end
        for (int i = 0; i < 1439; i++) begin
            drive_a(1'b1, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL freeze_pre: got %h, expected %h", g, e); end
        end
        for (int i = 0; i < 1000; i++) begin
            drive_a(1'b0, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL freeze_hold: got %h, expected %h", g, e); end
            if (g.line_req || g.frame_start) pulses++;
        end
        n_cmp++;
        if (a_x !== 10'd639 || a_y !== 10'd1 || pulses != 0) begin
            n_fail++;
            $display("FAIL freeze_state: got x=%0d y=%0d pulses=%0d, expected x=639 y=1 pulses=0", a_x, a_y, pulses);
        end
        drive_a(1'b1, 1'b0);
        e = qa.pop_front(); g = sample_a(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL freeze_resume: got %h, expected %h", g, e); end
        n_cmp++;
        if (g.line_req !== 1'b1 || g.nes_y_next !== 8'd1) begin
            n_fail++;
            $display("FAIL first_lr: got lr=%0d nyn=%0d, expected lr=1 nyn=1", g.line_req, g.nes_y_next);
        end
        $display("freeze: resumed with line_req at y=%0d x=%0d nes_y_next=%0d", g.y, g.x, g.nes_y_next);
    endtask

    task automatic test_mid_reset();
        out_t e, g;
        int fs_cnt = 0;
        for (int i = 0; i < 460; i++) begin
            drive_a(1'b1, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL midrst_pre: got %h, expected %h", g, e); end
        end
        n_cmp++;
        if (a_x !== 10'd300 || a_y !== 10'd2) begin
            n_fail++;
            $display("FAIL midrst_pos: got x=%0d y=%0d, expected x=300 y=2", a_x, a_y);
        end
        drive_a(1'b1, 1'b1);
        e = qa.pop_front(); g = sample_a(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL midrst_vals: got %h, expected %h", g, e); end
        for (int i = 0; i < 1000; i++) begin
            drive_a(1'b1, 1'b0);
            e = qa.pop_front(); g = sample_a(); n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL midrst_post: got %h, expected %h", g, e); end
            if (g.frame_start) fs_cnt++;
        end
        n_cmp++;
        if (fs_cnt != 0) begin n_fail++; $display("FAIL midrst_fs: got %0d pulses, expected 0", fs_cnt); end
        $display("mid_reset: restarted, now x=%0d y=%0d", a_x, a_y);
    endtask

    task automatic test_frames_small();
        out_t e, g;
        int fs_cnt = 0, fs_first = -1, fs_second = -1, lr_cnt = 0, vs_low = 0;
        drive_b(1'b0, 1'b1);
        e = qb.pop_front(); g = sample_b(); n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL frames_rst: got %h, expected %h", g, e); end
        for (int i = 0; i < 22410; i++) begin
            drive_b(1'b1, 1'b0);
            e = qb.pop_front(); g = sample_b(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL frames: got x=%0d y=%0d out=%h, expected x=%0d y=%0d out=%h",
                         g.x, g.y, g, e.x, e.y, e);
            end
            if (g.vs == 1'b0) vs_low++;
            if (g.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
                $display("frames: frame_start at cycle %0d x=%0d y=%0d", i, g.x, g.y);
            end
            if (g.line_req) begin
                lr_cnt++;
                $display("frames: line_req y=%0d nes_y_next=%0d", g.y, g.nes_y_next);
                if (g.y == 13) begin
                    n_cmp++;
                    if (g.nes_y_next !== 8'd0) begin n_fail++; $display("FAIL lr_last: got nyn=%0d, expected 0", g.nes_y_next); end
                end
                n_cmp++;
                if (g.y == 7) begin n_fail++; $display("FAIL lr_lastvis: got pulse at y=7, expected none"); end
            end
        end
        n_cmp++;
        if (fs_cnt != 2) begin n_fail++; $display("FAIL fs_count: got %0d, expected 2", fs_cnt); end
        n_cmp++;
        if (fs_second - fs_first != 11200) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clk, expected 11200", fs_second - fs_first);
        end
        n_cmp++;
        if (lr_cnt != 8) begin n_fail++; $display("FAIL lr_frame: got %0d, expected 8", lr_cnt); end
        n_cmp++;
        if (vs_low != 3200) begin n_fail++; $display("FAIL vs_width: got %0d clk low, expected 3200", vs_low); end
    endtask

    initial begin
        rst_a = 1'b1; ce_a = 1'b0; rst_b = 1'b1; ce_b = 1'b0;
        exp_a = reset_val();
        exp_b = reset_val();
        test_reset();
        test_every4th();
        test_window_linereq();
        test_freeze();
        test_mid_reset();
        test_frames_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_vga_timing.md
Name: nes_vga_timing

Overview:
- VGA 640x480@60 timing generator; consumes the 25 MHz pixel-enable produced by the clock block.
- Produces sync, pixel coordinates, and a 2x-scaled 256x240 NES window (512x480, centred horizontally).
- Issues per-line fetch requests to the NES line buffer reader.
- Sits between the clock block and the video output / line-buffer logic.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
NES_X0, 64, first screen column of NES window

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
ce_pix  in  1  pixel enable (25 MHz strobe); counters advance only when high
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
x  out  10  current column 0..799
y  out  10  current line 0..524
de  out  1  display enable (x<640 && y<480)
nes_act  out  1  inside NES window
nes_x  out  8  NES pixel column 0..255
nes_y  out  8  NES pixel line 0..239
line_req  out  1  one-clk pulse: fetch NES line nes_y_next
nes_y_next  out  8  line index accompanying line_req
frame_start  out  1  one-clk pulse at x=0,y=0 advance

Behaviour:
- All outputs registered; decoded from the registered x/y.
- Counters:
  - x increments when ce_pix=1.
  - At x=H_total-1 (799), x wraps to 0 and y increments.
  - At y=524 with x wrap, y wraps to 0.
  - When ce_pix=0, all state holds; pulses are not generated.
- Output timing: outputs reflect the new x/y in the same clk cycle the counters update (one clk after the ce_pix edge sample).
- hs=0 iff 656<=x<752; vs=0 iff 490<=y<492.
- de=1 iff x<640 && y<480.
- NES window:
  - nes_act=1 iff NES_X0<=x<NES_X0+512 && y<480.
  - nes_x=(x-NES_X0)>>1; nes_y=y>>1.
  - When nes_act=0, nes_x=0 and nes_y=0.
- line_req:
  - Single-clk pulse on the clk where x becomes 640 (start of h-blank), only when y is odd and y<479, or y=524.
  - nes_y_next=(y+1)>>1 for odd y; 0 when y=524.
  - This yields exactly 240 requests per frame, each one line ahead of display.
- frame_start: single-clk pulse on the clk where x,y both become 0 (i.e. on the wrap from 799,524).
- Consecutive ce_pix=1 every clk is legal; counters advance every clk.
- Reset:
  - x=0, y=0, hs=1, vs=1, de=0, nes_act=0, nes_x=0, nes_y=0, line_req=0, nes_y_next=0, frame_start=0.
  - Reset has priority over ce_pix.
  - Reset mid-frame restarts at 0,0 with no frame_start pulse for that restart.
  - First line_req after reset occurs at y=1, x=640.
- Widths: x and y are 10-bit with no overflow beyond the wrap values; the NES_X0 subtraction is done in 10 bits and then truncated.

Test Plan:
1. Reset, then ce_pix every 4th clk for 2 frames -> hs low for 96 enables starting at x=656; vs low on y=490,491; frame period 800*525*4 = 1,680,000 clk.
2. ce_pix held high -> x reaches 799 then 0; y increments on the same clk; 420,000 clk per frame; exactly one frame_start per frame.
3. Window check -> x=63: nes_act=0. x=64,y=0: nes_act=1, nes_x=0. x=575,y=479: nes_x=255, nes_y=239, nes_act=1. x=576: nes_act=0.
4. line_req count -> 240 pulses per frame. At y=1,x=640: nes_y_next=1. At y=477: nes_y_next=239. At y=524: nes_y_next=0. No pulse at y=479.
5. rst asserted at x=300,y=200 for 1 clk -> next clk all outputs at reset values; counting resumes from 0,0; no spurious frame_start.
6. ce_pix held low 1000 clk mid-line -> x, y and all outputs frozen; no pulses emitted.
